// File: rtl/bullet_fire_arbiter.sv
// bullet_fire_arbiter
//
// Picks one tank per shot and drives the single shared write port of the
// bullet array. Tanks are served round-robin. A tank may fire when its
// request is up, its cooldown has expired, its health is positive and it
// still has a free bullet slot. A granted shot is held on the write port
// until the array accepts it. After acceptance the tank's cooldown reloads.
//
// Ports
//   frame_clk           : the only clock
//   Reset_n             : synchronous, active-low reset
//   fire_req[t]         : level fire request per tank
//   tank_x/y[t]         : tank position (10 bits each)
//   tank_dir[t]         : facing: 0 up, 1 right, 2 down, 3 left
//   health[t]           : current health, two's complement
//   slot_busy[t]        : bit s set means bullet slot s of tank t is active
//   wr_valid/wr_ready   : write handshake into the bullet array
//   wr_tank/wr_slot     : write target
//   wr_data             : bullet word {9'b0, dir, y, x, 1'b1}
//   fire_ack[t]         : one-cycle pulse after tank t's bullet is written
//   cooling[t]          : high while tank t's cooldown counter is nonzero
module bullet_fire_arbiter #(
  parameter int TANK_NUM   = 2,
  parameter int BULLET_NUM = 8,
  parameter int COOLDOWN   = 15
) (
  input  logic                          frame_clk,
  input  logic                          Reset_n,
  input  logic [TANK_NUM-1:0]           fire_req,
  input  logic [9:0]                    tank_x    [TANK_NUM],
  input  logic [9:0]                    tank_y    [TANK_NUM],
  input  logic [1:0]                    tank_dir  [TANK_NUM],
  input  logic [31:0]                   health    [TANK_NUM],
  input  logic [BULLET_NUM-1:0]         slot_busy [TANK_NUM],
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [$clog2(TANK_NUM)-1:0]   wr_tank,
  output logic [$clog2(BULLET_NUM)-1:0] wr_slot,
  output logic [31:0]                   wr_data,
  output logic [TANK_NUM-1:0]           fire_ack,
  output logic [TANK_NUM-1:0]           cooling
);

  localparam int TW = $clog2(TANK_NUM);
  localparam int SW = $clog2(BULLET_NUM);
  localparam int CW = $clog2(COOLDOWN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                state_q,    state_d;
  logic [TW-1:0]         rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0]         cd_q [TANK_NUM];
  logic [CW-1:0]         cd_d [TANK_NUM];
  logic                  wr_valid_q, wr_valid_d;
  logic [TW-1:0]         wr_tank_q,  wr_tank_d;
  logic [SW-1:0]         wr_slot_q,  wr_slot_d;
  logic [31:0]           wr_data_q,  wr_data_d;
  logic [TANK_NUM-1:0]   fire_ack_q, fire_ack_d;

  logic [TANK_NUM-1:0]   eligible;
  logic                  grant_found;
  logic [TW-1:0]         grant;
  logic [SW-1:0]         free_slot;
  logic                  slot_found;
  int                    idx;

  // Per-tank fire eligibility and the registered cooling view.
  always_comb begin
    for (int t = 0; t < TANK_NUM; t++) begin
      eligible[t] = fire_req[t] && (cd_q[t] == '0) &&
                    ($signed(health[t]) > 0) && !(&slot_busy[t]);
      cooling[t]  = (cd_q[t] != '0);
    end
  end

  // Round-robin search starting at rr_ptr, then lowest free slot of the
  // winner. The wrap is a compare-and-subtract so TANK_NUM need not be a
  // power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int i = 0; i < TANK_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= TANK_NUM) idx = idx - TANK_NUM;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant       = TW'(idx);
      end
    end

    slot_found = 1'b0;
    free_slot  = '0;
    for (int s = 0; s < BULLET_NUM; s++) begin
      if (!slot_found && !slot_busy[grant][s]) begin
        slot_found = 1'b1;
        free_slot  = SW'(s);
      end
    end
  end

  // Next-state, payload, cooldown and ack logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wr_valid_d = wr_valid_q;
    wr_tank_d  = wr_tank_q;
    wr_slot_d  = wr_slot_q;
    wr_data_d  = wr_data_q;
    fire_ack_d = '0;

    // Cooldowns run down in every state and stop at zero.
    for (int t = 0; t < TANK_NUM; t++) begin
      cd_d[t] = (cd_q[t] != '0) ? cd_q[t] - CW'(1) : '0;
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          wr_valid_d = 1'b1;
          wr_tank_d  = grant;
          wr_slot_d  = free_slot;
          wr_data_d  = {9'd0, tank_dir[grant], tank_y[grant], tank_x[grant], 1'b1};
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // The shot is committed: inputs are not re-checked while waiting.
        if (wr_ready) begin
          wr_valid_d            = 1'b0;
          fire_ack_d[wr_tank_q] = 1'b1;
          cd_d[wr_tank_q]       = CW'(COOLDOWN);  // reload wins over decrement
          rr_ptr_d              = (wr_tank_q == TW'(TANK_NUM - 1)) ? '0 : wr_tank_q + TW'(1);
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!Reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_tank_q  <= '0;
      wr_slot_q  <= '0;
      wr_data_q  <= '0;
      fire_ack_q <= '0;
      // NOTE: the cooldown array is a handful of flops and must start at zero, so it is reset like any other state.
      for (int t = 0; t < TANK_NUM; t++) cd_q[t] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_tank_q  <= wr_tank_d;
      wr_slot_q  <= wr_slot_d;
      wr_data_q  <= wr_data_d;
      fire_ack_q <= fire_ack_d;
      for (int t = 0; t < TANK_NUM; t++) cd_q[t] <= cd_d[t];
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_tank  = wr_tank_q;
  assign wr_slot  = wr_slot_q;
  assign wr_data  = wr_data_q;
  assign fire_ack = fire_ack_q;

endmodule

// File: tb/tb_bullet_fire_arbiter.sv
// Testbench for bullet_fire_arbiter. A reference model keyed on cycle
// stamps predicts each shot and pushes it into a scoreboard queue; a monitor
// on the falling edge compares the DUT's write port, acks and cooling flags.
module tb_bullet_fire_arbiter;
  localparam int T = 2;
  localparam int B = 8;
  localparam int C = 15;

  logic          frame_clk = 1'b0;
  logic          Reset_n;
  logic [T-1:0]  fire_req;
  logic [9:0]    tank_x    [T];
  logic [9:0]    tank_y    [T];
  logic [1:0]    tank_dir  [T];
  logic [31:0]   health    [T];
  logic [B-1:0]  slot_busy [T];
  logic          wr_valid;
  logic          wr_ready;
  logic [0:0]    wr_tank;
  logic [2:0]    wr_slot;
  logic [31:0]   wr_data;
  logic [T-1:0]  fire_ack;
  logic [T-1:0]  cooling;

  bullet_fire_arbiter #(.TANK_NUM(T), .BULLET_NUM(B), .COOLDOWN(C)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .fire_req  (fire_req),
    .tank_x    (tank_x),
    .tank_y    (tank_y),
    .tank_dir  (tank_dir),
    .health    (health),
    .slot_busy (slot_busy),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_tank   (wr_tank),
    .wr_slot   (wr_slot),
    .wr_data   (wr_data),
    .fire_ack  (fire_ack),
    .cooling   (cooling)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          tank;
    int          slot;
    logic [31:0] data;
  } shot_t;

  shot_t        exp_q[$];
  int           cyc = 0;
  int           last_acc[T] = '{-1000, -1000};
  int           rr = 0;
  bit           pend = 0;
  int           pend_tank = 0;
  int           pend_slot = 0;
  bit           exp_valid = 0;
  logic [T-1:0] exp_ack = '0;
  logic [T-1:0] exp_cool = '0;
  int           m_acc_tank = -1;
  int           m_acc_slot = 0;

  function automatic int first_free(input logic [B-1:0] busy);
    for (int s = 0; s < B; s++) if (!busy[s]) return s;
    return -1;
  endfunction

  // A tank that was accepted at edge A may be granted again from edge A+C+1.
  function automatic bit can_fire(input int t);
    return fire_req[t] && (cyc - last_acc[t] > C) &&
           ($signed(health[t]) > 0) && (first_free(slot_busy[t]) >= 0);
  endfunction

  always @(posedge frame_clk) begin
    cyc++;
    m_acc_tank = -1;
    exp_ack    = '0;
    if (!Reset_n) begin
      pend = 0;
      rr   = 0;
      exp_q.delete();
      for (int t = 0; t < T; t++) last_acc[t] = -1000;
    end else if (pend) begin
      if (wr_ready) begin
        pend               = 0;
        m_acc_tank         = pend_tank;
        m_acc_slot         = pend_slot;
        exp_ack[pend_tank] = 1'b1;
        last_acc[pend_tank] = cyc;
        rr                 = (pend_tank + 1) % T;
      end
    end else begin
      for (int i = 0; i < T; i++) begin
        int t;
        t = (rr + i) % T;
        if (!pend && can_fire(t)) begin
          shot_t s;
          pend      = 1;
          pend_tank = t;
          pend_slot = first_free(slot_busy[t]);
          s.tank    = t;
          s.slot    = pend_slot;
          s.data    = {9'd0, tank_dir[t], tank_y[t], tank_x[t], 1'b1};
          exp_q.push_back(s);
        end
      end
    end
    exp_valid = pend;
    for (int t = 0; t < T; t++) exp_cool[t] = (cyc - last_acc[t]) < C;
  end

  // ---------------- monitor ----------------
  always @(negedge frame_clk) begin
    check("wr_valid", {63'd0, wr_valid}, {63'd0, exp_valid});
    check("fire_ack", {62'd0, fire_ack}, {62'd0, exp_ack});
    check("cooling",  {62'd0, cooling},  {62'd0, exp_cool});
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL payload: wr_valid high, got tank %0d slot %0d but expected no pending shot",
                 wr_tank, wr_slot);
      end else begin
        check("wr_tank", {63'd0, wr_tank}, 64'(exp_q[0].tank));
        check("wr_slot", {61'd0, wr_slot}, 64'(exp_q[0].slot));
        check("wr_data", {32'd0, wr_data}, {32'd0, exp_q[0].data});
        if (wr_ready && Reset_n) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  bit auto_busy = 0;

  // Inputs change 2 time units after the rising edge; slot_busy can mirror
  // the model's accepted shots so a held request walks through the slots.
  task automatic step();
    @(posedge frame_clk);
    #2;
    if (auto_busy && m_acc_tank >= 0) slot_busy[m_acc_tank][m_acc_slot] = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    fire_req = '0;
    wr_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    int cool_len;
    int valid_seen;
    bit got;

    Reset_n  = 1'b0;
    fire_req = '0;
    wr_ready = 1'b0;
    for (int t = 0; t < T; t++) begin
      tank_x[t] = '0; tank_y[t] = '0; tank_dir[t] = '0;
      health[t] = 32'd1; slot_busy[t] = '0;
    end
    repeat (3) step();
    check("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    check("rst_wr_tank",  {63'd0, wr_tank},  64'd0);
    check("rst_wr_slot",  {61'd0, wr_slot},  64'd0);
    check("rst_wr_data",  {32'd0, wr_data},  64'd0);
    check("rst_cooling",  {62'd0, cooling},  64'd0);
    Reset_n = 1'b1;

    // First shot of tank 0 and its cooldown length.
    tank_x[0] = 10'd100; tank_y[0] = 10'd200; tank_dir[0] = 2'd1;
    health[0] = 32'd5;   slot_busy[0] = '0;
    wr_ready  = 1'b1;    fire_req = 2'b01; auto_busy = 1;
    step();
    check("first_valid", {63'd0, wr_valid}, 64'd1);
    check("first_tank",  {63'd0, wr_tank},  64'd0);
    check("first_slot",  {61'd0, wr_slot},  64'd0);
    check("first_data",  {32'd0, wr_data},  64'h0000_0000_0026_40C9);
    step();
    check("first_ack",   {62'd0, fire_ack}, 64'd1);
    check("first_valid_drop", {63'd0, wr_valid}, 64'd0);
    cool_len = 0;
    for (int i = 0; i < 30; i++) begin
      if (!cooling[0]) break;
      cool_len++;
      step();
    end
    check("cool_len", 64'(cool_len), 64'd15);
    repeat (40) step();
    auto_busy = 0;

    // Both tanks contend; then a stall with wr_ready low for 5 cycles.
    idle_gap(20);
    slot_busy[0] = '0; slot_busy[1] = '0;
    tank_x[1] = 10'd321; tank_y[1] = 10'd45; tank_dir[1] = 2'd3; health[1] = 32'd9;
    fire_req = 2'b11;
    repeat (40) step();
    wr_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = wr_valid;
    end
    check("stall_valid_seen", {63'd0, got}, 64'd1);
    repeat (5) step();
    wr_ready = 1'b1;
    repeat (20) step();

    // Blocked tank 1: full slots, zero health, negative health.
    idle_gap(20);
    valid_seen = 0;
    fire_req = 2'b10; slot_busy[1] = 8'hFF;
    for (int i = 0; i < 50; i++) begin step(); valid_seen += int'(wr_valid); end
    slot_busy[1] = '0; health[1] = 32'd0;
    for (int i = 0; i < 50; i++) begin step(); valid_seen += int'(wr_valid); end
    health[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 50; i++) begin step(); valid_seen += int'(wr_valid); end
    check("blocked_no_valid", 64'(valid_seen), 64'd0);
    health[1] = 32'd3;

    // Only the top slot free.
    idle_gap(20);
    slot_busy[0] = 8'h7F; fire_req = 2'b01;
    step();
    check("top_slot_valid", {63'd0, wr_valid}, 64'd1);
    check("top_slot",       {61'd0, wr_slot},  64'd7);
    fire_req = '0;

    // A committed shot survives health, request and slot changes.
    idle_gap(20);
    slot_busy[0] = '0; health[0] = 32'd5; wr_ready = 1'b0; fire_req = 2'b01;
    step();
    check("commit_valid", {63'd0, wr_valid}, 64'd1);
    health[0] = 32'd0; fire_req = '0; slot_busy[0] = 8'hFF;
    repeat (3) step();
    wr_ready = 1'b1;
    step();
    check("commit_ack", {62'd0, fire_ack}, 64'd1);

    // Reset in the middle of an issue drops the shot.
    health[0] = 32'd5; slot_busy[0] = '0;
    idle_gap(20);
    wr_ready = 1'b0; fire_req = 2'b01;
    step();
    check("pre_rst_valid", {63'd0, wr_valid}, 64'd1);
    Reset_n = 1'b0; fire_req = '0;
    step();
    check("mid_rst_valid",   {63'd0, wr_valid}, 64'd0);
    check("mid_rst_ack",     {62'd0, fire_ack}, 64'd0);
    check("mid_rst_cooling", {62'd0, cooling},  64'd0);
    Reset_n = 1'b1; wr_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      fire_req = T'($urandom);
      wr_ready = ($urandom_range(0, 3) != 0);
      Reset_n  = ($urandom_range(0, 199) != 0);
      for (int t = 0; t < T; t++) begin
        tank_x[t]   = 10'($urandom);
        tank_y[t]   = 10'($urandom);
        tank_dir[t] = 2'($urandom);
        case ($urandom_range(0, 5))
          0: health[t] = 32'd0;
          1: health[t] = 32'hFFFF_FFFF;
          2: health[t] = 32'h8000_0000;
          3: health[t] = 32'h7FFF_FFFF;
          default: health[t] = 32'($urandom_range(1, 100));
        endcase
        case ($urandom_range(0, 5))
          0: slot_busy[t] = 8'hFF;
          1: slot_busy[t] = 8'h7F;
          2: slot_busy[t] = 8'h00;
          default: slot_busy[t] = 8'($urandom);
        endcase
      end
      step();
    end
    Reset_n = 1'b1;
    idle_gap(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
